// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between ibus and dbus.
// Data accesses win unless ibus has lost STARVE_MAX arbitrations in a row.
module mem_arbiter #(
   parameter int AW         = 22,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          rst_b,
   input  logic          ibus_req,
   input  logic [AW-1:0] ibus_addr,
   output logic          ibus_ready,
   output logic          ibus_rvalid,
   output logic [31:0]   ibus_rdata,
   input  logic          dbus_req,
   input  logic          dbus_write,
   input  logic [AW-1:0] dbus_addr,
   input  logic [31:0]   dbus_wdata,
   input  logic [3:0]    dbus_wstrb,
   output logic          dbus_ready,
   output logic          dbus_rvalid,
   output logic [31:0]   dbus_rdata,
   output logic          ram_en,
   output logic [3:0]    ram_we,
   output logic [AW-3:0] ram_addr,
   output logic [31:0]   ram_wdata,
   input  logic [31:0]   ram_rdata
);

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

   localparam logic [7:0] SMAX = 8'(STARVE_MAX);

   logic       ib_sel;
   logic       db_sel;
   logic       db_rd;
   logic [7:0] starve_q, starve_d;
   logic       pend_q, pend_d;
   owner_e     owner_q, owner_d;

   // Byte-lane bits never reach the word-addressed RAM.
   logic       unused_lanes;
   assign unused_lanes = ^{ibus_addr[1:0], dbus_addr[1:0]};

   always_comb begin
      ib_sel = ibus_req & (~dbus_req | (starve_q == SMAX));
      db_sel = dbus_req & ~ib_sel;
      db_rd  = db_sel & ~dbus_write;
   end

   always_comb begin
      pend_d   = ib_sel | db_rd;
      owner_d  = owner_q;
      starve_d = 8'd0;
      if (ib_sel) begin
         owner_d = OWN_I;
      end else if (db_rd) begin
         owner_d = OWN_D;
      end
      if (ibus_req & ~ib_sel) begin
         starve_d = (starve_q >= SMAX) ? SMAX : starve_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         starve_q <= 8'd0;
         pend_q   <= 1'b0;
         owner_q  <= OWN_I;
      end else begin
         starve_q <= starve_d;
         pend_q   <= pend_d;
         owner_q  <= owner_d;
      end
   end

   always_comb begin
      ibus_ready = rst_b & ib_sel;
      dbus_ready = rst_b & db_sel;
      ram_en     = rst_b & (ib_sel | db_sel);
      ram_we     = 4'b0000;
      if (rst_b & db_sel & dbus_write) begin
         ram_we = dbus_wstrb;
      end
      ram_addr   = ib_sel ? ibus_addr[AW-1:2] : dbus_addr[AW-1:2];
      ram_wdata  = dbus_wdata;
   end

   assign ibus_rvalid = pend_q & (owner_q == OWN_I);
   assign dbus_rvalid = pend_q & (owner_q == OWN_D);
   assign ibus_rdata  = ram_rdata;
   assign dbus_rdata  = ram_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus hand-written multi-cycle sequences.
// A behavioural RAM answers the arbiter's commands with one-cycle latency.
module tb_mem_arbiter;

   localparam int AW = 22;

   logic          clk = 1'b0;
   logic          rst_b;
   logic          ibus_req;
   logic [AW-1:0] ibus_addr;
   logic          ibus_ready;
   logic          ibus_rvalid;
   logic [31:0]   ibus_rdata;
   logic          dbus_req;
   logic          dbus_write;
   logic [AW-1:0] dbus_addr;
   logic [31:0]   dbus_wdata;
   logic [3:0]    dbus_wstrb;
   logic          dbus_ready;
   logic          dbus_rvalid;
   logic [31:0]   dbus_rdata;
   logic          ram_en;
   logic [3:0]    ram_we;
   logic [AW-3:0] ram_addr;
   logic [31:0]   ram_wdata;
   logic [31:0]   ram_rdata = 32'h0;

   int ntests = 0;
   int nfail  = 0;

   mem_arbiter #(.AW(AW), .STARVE_MAX(4)) dut (
      .clk(clk), .rst_b(rst_b),
      .ibus_req(ibus_req), .ibus_addr(ibus_addr),
      .ibus_ready(ibus_ready), .ibus_rvalid(ibus_rvalid),
      .ibus_rdata(ibus_rdata),
      .dbus_req(dbus_req), .dbus_write(dbus_write),
      .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
      .dbus_wstrb(dbus_wstrb), .dbus_ready(dbus_ready),
      .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [int unsigned];
   logic [31:0] ram_w;

   function automatic logic [31:0] rd(input int unsigned a);
      return mem.exists(a) ? mem[a] : 32'h0;
   endfunction

   always @(posedge clk) begin
      if (ram_en) begin
         ram_w = rd(32'(ram_addr));
         ram_rdata <= ram_w;
         for (int b = 0; b < 4; b++)
            if (ram_we[b]) ram_w[8*b +: 8] = ram_wdata[8*b +: 8];
         if (ram_we != 4'b0) mem[32'(ram_addr)] = ram_w;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic ir, input logic [AW-1:0] ia,
                        input logic dr, input logic dw,
                        input logic [AW-1:0] da, input logic [31:0] wd,
                        input logic [3:0] ws);
      ibus_req   = ir;
      ibus_addr  = ia;
      dbus_req   = dr;
      dbus_write = dw;
      dbus_addr  = da;
      dbus_wdata = wd;
      dbus_wstrb = ws;
   endtask

   task automatic idle();
      drive(1'b0, '0, 1'b0, 1'b0, '0, 32'h0, 4'h0);
   endtask

   typedef struct {
      logic          ir;
      logic [AW-1:0] ia;
      logic          dr;
      logic          dw;
      logic [AW-1:0] da;
      logic [31:0]   wd;
      logic [3:0]    ws;
      logic          e_ir;
      logic          e_dr;
      logic          e_en;
      logic [3:0]    e_we;
      logic [AW-3:0] e_addr;
      logic          e_irv;
      logic          e_drv;
      logic [31:0]   e_data;
   } vec_t;

   vec_t vecs [9];

   initial begin
      mem[32'h40]    = 32'h00000013;
      mem[32'h0]     = 32'h00000297;
      mem[32'h2]     = 32'hA0A0A0A2;
      mem[32'h3]     = 32'h33333333;
      mem[32'h4]     = 32'h44444444;
      mem[32'h8]     = 32'h77777777;
      mem[32'hA]     = 32'h12345678;
      mem[32'hFFD]   = 32'h11223344;
      mem[32'hFFFFF] = 32'h5A5A5A5A;

      vecs[0] = '{1, 22'h100, 0, 0, 22'h0, 32'h0, 4'h0,
                  1, 0, 1, 4'h0, 20'h40, 1, 0, 32'h00000013};
      vecs[1] = '{0, 22'h0, 1, 0, 22'h8, 32'h0, 4'h0,
                  0, 1, 1, 4'h0, 20'h2, 0, 1, 32'hA0A0A0A2};
      vecs[2] = '{1, 22'h10, 1, 0, 22'hC, 32'h0, 4'h0,
                  0, 1, 1, 4'h0, 20'h3, 0, 1, 32'h33333333};
      vecs[3] = '{0, 22'h0, 1, 1, 22'h20, 32'hDEADBEEF, 4'h0,
                  0, 1, 1, 4'h0, 20'h8, 0, 0, 32'h0};
      vecs[4] = '{0, 22'h0, 1, 1, 22'h24, 32'hCAFEF00D, 4'hF,
                  0, 1, 1, 4'hF, 20'h9, 0, 0, 32'h0};
      vecs[5] = '{1, 22'h3FFFFF, 0, 0, 22'h0, 32'h0, 4'h0,
                  1, 0, 1, 4'h0, 20'hFFFFF, 1, 0, 32'h5A5A5A5A};
      vecs[6] = '{0, 22'h0, 0, 0, 22'h0, 32'h0, 4'h0,
                  0, 0, 0, 4'h0, 20'h0, 0, 0, 32'h0};
      vecs[7] = '{0, 22'h0, 1, 0, 22'hF, 32'h0, 4'h0,
                  0, 1, 1, 4'h0, 20'h3, 0, 1, 32'h33333333};
      vecs[8] = '{1, 22'h100, 1, 1, 22'h28, 32'h0000BEEF, 4'h3,
                  0, 1, 1, 4'h3, 20'hA, 0, 0, 32'h0};

      // Reset state with both requests pending.
      rst_b = 1'b1;
      drive(1'b1, 22'h100, 1'b1, 1'b1, 22'h20, 32'h1, 4'hF);
      #1 rst_b = 1'b0;
      #2;
      chk("rst_iready", 32'(ibus_ready), 32'h0);
      chk("rst_dready", 32'(dbus_ready), 32'h0);
      chk("rst_en", 32'(ram_en), 32'h0);
      chk("rst_we", 32'(ram_we), 32'h0);
      chk("rst_irv", 32'(ibus_rvalid), 32'h0);
      chk("rst_drv", 32'(dbus_rvalid), 32'h0);
      @(negedge clk);
      idle();
      @(negedge clk);
      rst_b = 1'b1;

      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         drive(vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].dw,
               vecs[i].da, vecs[i].wd, vecs[i].ws);
         #2;
         chk($sformatf("v%0d_iready", i), 32'(ibus_ready), 32'(vecs[i].e_ir));
         chk($sformatf("v%0d_dready", i), 32'(dbus_ready), 32'(vecs[i].e_dr));
         chk($sformatf("v%0d_en", i), 32'(ram_en), 32'(vecs[i].e_en));
         chk($sformatf("v%0d_we", i), 32'(ram_we), 32'(vecs[i].e_we));
         if (vecs[i].e_en)
            chk($sformatf("v%0d_addr", i), 32'(ram_addr), 32'(vecs[i].e_addr));
         @(negedge clk);
         idle();
         chk($sformatf("v%0d_irv", i), 32'(ibus_rvalid), 32'(vecs[i].e_irv));
         chk($sformatf("v%0d_drv", i), 32'(dbus_rvalid), 32'(vecs[i].e_drv));
         if (vecs[i].e_irv)
            chk($sformatf("v%0d_idata", i), ibus_rdata, vecs[i].e_data);
         if (vecs[i].e_drv)
            chk($sformatf("v%0d_ddata", i), dbus_rdata, vecs[i].e_data);
      end
      chk("mem_strb0", rd(32'h8), 32'h77777777);
      chk("mem_full", rd(32'h9), 32'hCAFEF00D);
      chk("mem_half", rd(32'hA), 32'h1234BEEF);

      // Simultaneous ibus read and dbus write.
      begin
         int nirv;
         nirv = 0;
         @(negedge clk);
         drive(1'b1, 22'h0, 1'b1, 1'b1, 22'h3FF0, 32'h2000, 4'hF);
         #2;
         chk("a_c0_dready", 32'(dbus_ready), 32'h1);
         chk("a_c0_iready", 32'(ibus_ready), 32'h0);
         @(negedge clk);
         dbus_req = 1'b0;
         #2;
         chk("a_c1_iready", 32'(ibus_ready), 32'h1);
         chk("a_c1_addr", 32'(ram_addr), 32'h0);
         chk("a_mem", rd(32'hFFC), 32'h00002000);
         nirv += int'(ibus_rvalid);
         @(negedge clk);
         idle();
         #2;
         chk("a_idata", ibus_rdata, 32'h00000297);
         nirv += int'(ibus_rvalid);
         @(negedge clk);
         #2;
         nirv += int'(ibus_rvalid);
         chk("a_nirv", 32'(nirv), 32'h1);
      end

      // Starvation: ibus wins on cycles 4 and 9 under continuous dbus load.
      @(negedge clk);
      drive(1'b1, 22'h40, 1'b1, 1'b0, 22'h8, 32'h0, 4'h0);
      for (int c = 0; c < 10; c++) begin
         #2;
         chk($sformatf("b_c%0d_iready", c), 32'(ibus_ready),
             32'((c == 4) || (c == 9)));
         chk($sformatf("b_c%0d_dready", c), 32'(dbus_ready),
             32'(!((c == 4) || (c == 9))));
         @(negedge clk);
      end
      idle();

      // Alternating back-to-back reads.
      @(negedge clk);
      drive(1'b1, 22'h8, 1'b0, 1'b0, 22'h0, 32'h0, 4'h0);
      #2 chk("c_c0_iready", 32'(ibus_ready), 32'h1);
      @(negedge clk);
      drive(1'b0, 22'h0, 1'b1, 1'b0, 22'hC, 32'h0, 4'h0);
      #2;
      chk("c_c1_dready", 32'(dbus_ready), 32'h1);
      chk("c_c1_irv", 32'(ibus_rvalid), 32'h1);
      chk("c_c1_drv", 32'(dbus_rvalid), 32'h0);
      chk("c_c1_data", ibus_rdata, 32'hA0A0A0A2);
      @(negedge clk);
      drive(1'b1, 22'h10, 1'b0, 1'b0, 22'h0, 32'h0, 4'h0);
      #2;
      chk("c_c2_iready", 32'(ibus_ready), 32'h1);
      chk("c_c2_irv", 32'(ibus_rvalid), 32'h0);
      chk("c_c2_drv", 32'(dbus_rvalid), 32'h1);
      chk("c_c2_data", dbus_rdata, 32'h33333333);
      @(negedge clk);
      idle();
      #2;
      chk("c_c3_irv", 32'(ibus_rvalid), 32'h1);
      chk("c_c3_drv", 32'(dbus_rvalid), 32'h0);
      chk("c_c3_data", ibus_rdata, 32'h44444444);

      // Byte store then load of the same word.
      @(negedge clk);
      drive(1'b0, 22'h0, 1'b1, 1'b1, 22'h3FF4, 32'h0000AB00, 4'h2);
      #2;
      chk("d_we", 32'(ram_we), 32'h2);
      chk("d_addr", 32'(ram_addr), 32'hFFD);
      @(negedge clk);
      dbus_write = 1'b0;
      dbus_wstrb = 4'h0;
      #2;
      chk("d_ld_ready", 32'(dbus_ready), 32'h1);
      chk("d_st_norv", 32'(dbus_rvalid), 32'h0);
      @(negedge clk);
      idle();
      #2;
      chk("d_drv", 32'(dbus_rvalid), 32'h1);
      chk("d_data", dbus_rdata, 32'h1122AB44);

      // Reset in the cycle after a dbus read grant.
      @(negedge clk);
      drive(1'b0, 22'h0, 1'b1, 1'b0, 22'hC, 32'h0, 4'h0);
      #2 chk("e_dready", 32'(dbus_ready), 32'h1);
      @(negedge clk);
      chk("e_drv_pre", 32'(dbus_rvalid), 32'h1);
      drive(1'b1, 22'h40, 1'b1, 1'b0, 22'h8, 32'h0, 4'h0);
      #1 rst_b = 1'b0;
      #1;
      chk("e_drv_rst", 32'(dbus_rvalid), 32'h0);
      chk("e_irv_rst", 32'(ibus_rvalid), 32'h0);
      chk("e_iready_rst", 32'(ibus_ready), 32'h0);
      chk("e_dready_rst", 32'(dbus_ready), 32'h0);
      chk("e_en_rst", 32'(ram_en), 32'h0);
      @(negedge clk);
      @(negedge clk);
      chk("e_drv_hold", 32'(dbus_rvalid), 32'h0);
      rst_b = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #2;
         chk($sformatf("e_c%0d_iready", c), 32'(ibus_ready), 32'(c == 4));
         @(negedge clk);
      end
      idle();
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
